// File: rtl/vedic_pkg.sv
// ============================================================================
// Module : vedic_pkg
// Brief  : Shared widths, FSM state encoding and per-step shift amounts for
//          the iterative 24x24 Vedic multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vedic_pkg;

  localparam int HALF_W = 12;
  localparam int OP_W   = 24;
  localparam int PROD_W = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Weight of each partial product: aLbL, aHbL, aLbH, aHbH
  function automatic logic [5:0] step_shift(input logic [1:0] step);
    case (step)
      2'd0:    step_shift = 6'd0;
      2'd1:    step_shift = 6'd12;
      2'd2:    step_shift = 6'd12;
      default: step_shift = 6'd24;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/vedic_24_iter_if.sv
// ============================================================================
// Module : vedic_24_iter_if
// Brief  : Operand and product valid/ready channels of the iterative multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface vedic_24_iter_if;
  import vedic_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] p;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p
  );

endinterface

`default_nettype wire

// File: rtl/vedic_12.sv
// ============================================================================
// Module : vedic_12
// Brief  : Combinational 12x12 unsigned multiplier, urdhva-tiryagbhyam form
//          over 6-bit digits (vertical and crosswise partial products).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vedic_12 (
  input  wire logic [11:0] x,
  input  wire logic [11:0] y,
  output logic      [23:0] pp
);

  logic [11:0] w_ll;
  logic [11:0] w_lh;
  logic [11:0] w_hl;
  logic [11:0] w_hh;
  logic [12:0] w_mid;

  assign w_ll  = {6'b0, x[5:0]}  * {6'b0, y[5:0]};
  assign w_lh  = {6'b0, x[5:0]}  * {6'b0, y[11:6]};
  assign w_hl  = {6'b0, x[11:6]} * {6'b0, y[5:0]};
  assign w_hh  = {6'b0, x[11:6]} * {6'b0, y[11:6]};
  assign w_mid = {1'b0, w_lh} + {1'b0, w_hl};

  // Crosswise sum lands on the middle digit
  assign pp = {w_hh, w_ll} + {5'b0, w_mid, 6'b0};

endmodule

`default_nettype wire

// File: rtl/vedic_24_iter.sv
// ============================================================================
// Module : vedic_24_iter
// Brief  : Iterative 24x24 unsigned multiplier; four half-products through a
//          single vedic_12, accumulated into a 48-bit product register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vedic_24_iter
  import vedic_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     rst_n,
  vedic_24_iter_if.slave bus
);

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_step, w_step_nxt;
  logic [OP_W-1:0]   r_a, w_a_nxt;
  logic [OP_W-1:0]   r_b, w_b_nxt;
  logic [PROD_W-1:0] r_p, w_p_nxt;
  logic              r_in_ready, w_in_ready_nxt;
  logic              r_out_valid, w_out_valid_nxt;

  logic [HALF_W-1:0] w_x;
  logic [HALF_W-1:0] w_y;
  logic [OP_W-1:0]   w_pp;
  logic [PROD_W-1:0] w_term;

  // step[0] picks the high half of a, step[1] the high half of b
  assign w_x    = r_step[0] ? r_a[OP_W-1:HALF_W] : r_a[HALF_W-1:0];
  assign w_y    = r_step[1] ? r_b[OP_W-1:HALF_W] : r_b[HALF_W-1:0];
  assign w_term = {{(PROD_W-OP_W){1'b0}}, w_pp} << step_shift(r_step);

  vedic_12 u_vedic_12 (
    .x  (w_x),
    .y  (w_y),
    .pp (w_pp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_step      <= 2'd0;
      r_a         <= '0;
      r_b         <= '0;
      r_p         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_step      <= w_step_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_p         <= w_p_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_step_nxt      = r_step;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_p_nxt         = r_p;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      IDLE: begin
        w_in_ready_nxt = 1'b1;
        if (bus.in_valid && r_in_ready) begin
          w_a_nxt        = bus.a;
          w_b_nxt        = bus.b;
          w_p_nxt        = '0;
          w_step_nxt     = 2'd0;
          w_in_ready_nxt = 1'b0;
          w_state_nxt    = MUL;
        end
      end
      MUL: begin
        w_p_nxt    = r_p + w_term;
        w_step_nxt = r_step + 2'd1;
        if (r_step == 2'd3) begin
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready && r_out_valid) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.p         = r_p;

endmodule

`default_nettype wire

// File: tb/tb_vedic_24_iter.sv
// ============================================================================
// Module : tb_vedic_24_iter
// Brief  : Self-checking bench for vedic_24_iter: vector table, corner-case
//          sequences and a throttled random run against a product scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vedic_24_iter;

  logic clk;
  logic rst_n;

  vedic_24_iter_if bus ();

  vedic_24_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] exp;
  } vec_t;

  localparam int N_RAND = 3000;

  int          checks;
  int          failures;
  logic [47:0] exp_q[$];
  vec_t        vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; runs one operation, holding out_ready low for hold cycles
  task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                        input logic [47:0] exp, input int hold);
    int          n;
    logic [47:0] held_p;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_timeout", {63'b0, bus.in_ready}, 64'd1);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("in_ready_busy", {63'b0, bus.in_ready}, 64'd0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'd4);
    held_p = bus.p;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'(i % 2);
      bus.a        = 24'($urandom);
      bus.b        = 24'($urandom);
      @(negedge clk);
      check("bp_p_stable", {16'b0, bus.p}, {16'b0, held_p});
      check("bp_out_valid", {63'b0, bus.out_valid}, 64'd1);
      check("bp_in_ready", {63'b0, bus.in_ready}, 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("product", {16'b0, bus.p}, {16'b0, exp_q.pop_front()});
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("consumed_out_valid", {63'b0, bus.out_valid}, 64'd0);
    check("consumed_in_ready", {63'b0, bus.in_ready}, 64'd1);
  endtask

  initial begin
    int          sent;
    int          got;
    int          cyc;
    int          seen_valid;
    logic [23:0] ra;
    logic [23:0] rb;
    logic        orr;
    logic        ivv;

    checks        = 0;
    failures      = 0;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
    vecs[1] = '{24'h001000, 24'h000003, 48'h000000003000};
    vecs[2] = '{24'h000001, 24'hFFF000, 48'h000000FFF000};
    vecs[3] = '{24'h000000, 24'hFFFFFF, 48'h000000000000};
    vecs[4] = '{24'hFFFFFF, 24'h000001, 48'h000000FFFFFF};
    vecs[5] = '{24'h000FFF, 24'h000FFF, 48'h000000FFE001};
    vecs[6] = '{24'h800000, 24'h800000, 48'h400000000000};
    vecs[7] = '{24'h123456, 24'h000010, 48'h000001234560};

    // Asynchronous reset asserted mid-cycle
    #3 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    check("rst_p", {16'b0, bus.p}, 64'd0);
    check("rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_low", {63'b0, bus.in_ready}, 64'd0);
    @(negedge clk);
    check("rel_in_ready_high", {63'b0, bus.in_ready}, 64'd1);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, 0);

    // Backpressure with in_valid toggling during DONE
    run_op(24'hABCDEF, 24'h13579B, 48'hABCDEF * 48'h13579B, 10);

    // Reset pulse while step2 is the current step
    bus.a        = 24'h123456;
    bus.b        = 24'h654321;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    check("midrst_p", {16'b0, bus.p}, 64'd0);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid++;
    end
    check("midrst_no_output", 64'(seen_valid), 64'd0);
    run_op(24'h000002, 24'h000005, 48'h00000000000A, 0);

    // Throttled random run
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < N_RAND && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      orr = 1'($urandom_range(0, 1));
      if (bus.out_valid && orr) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_output", 64'd1, 64'd0);
        end else begin
          check("rand_product", {16'b0, bus.p}, {16'b0, exp_q.pop_front()});
        end
        got++;
      end
      case ($urandom_range(0, 7))
        0:       ra = 24'h000000;
        1:       ra = 24'hFFFFFF;
        default: ra = 24'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 24'h000000;
        1:       rb = 24'hFFFFFF;
        default: rb = 24'($urandom);
      endcase
      ivv = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
      if (ivv && bus.in_ready) begin
        exp_q.push_back({24'b0, ra} * {24'b0, rb});
        sent++;
      end
      bus.out_ready = orr;
      bus.in_valid  = ivv;
      bus.a         = ra;
      bus.b         = rb;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("rand_sent", 64'(sent), 64'(N_RAND));
    check("rand_got", 64'(got), 64'(N_RAND));
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
